// File: rtl/io_bus_pkg.sv
// Shared types and constants for the MMIO bus arbiter: FSM states, request record, address map.
package io_bus_pkg;

   localparam int unsigned AW_DEF = 12;
   localparam int unsigned DW_DEF = 32;

   localparam logic [AW_DEF-1:0] SW_ADDR  = 12'h070;
   localparam logic [AW_DEF-1:0] LED_ADDR = 12'h060;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } io_state_t;

   typedef struct packed {
      logic              we;
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] wdata;
   } io_req_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Two-requester MMIO bus bundle; slave = arbiter side, master = requesters and peripheral side.
interface io_bus_arbiter_if
   import io_bus_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
);
   logic          m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [AW-1:0] io_addr;
   logic          io_we;
   logic [DW-1:0] io_wdata, io_rdata;
   logic          busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, io_rdata,
      output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
             io_addr, io_we, io_wdata, busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, io_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
             io_addr, io_we, io_wdata, busy
   );

endinterface

// File: rtl/io_arb_pick.sv
// Combinational winner select for two requesters. IO_ARB_RR_EN: ties go to ptr; otherwise m0 wins.
module io_arb_pick (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       win_vld,
   output logic       win
);

   assign win_vld = |req;

`ifdef IO_ARB_RR_EN
   // ptr names the master preferred on a tie
   assign win = req[1] & (~req[0] | ptr);
`else
   logic unused_ptr;
   assign unused_ptr = ptr;
   assign win        = req[1] & ~req[0];
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master MMIO bus arbiter with fixed ACCESS/WAIT/RESP schedule.
// Define IO_ARB_RR_EN for round-robin tie breaking; default build is fixed priority (m0 first).
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int unsigned RD_LAT = 1  // 0..7
) (
   input  logic        clk_i,
   input  logic        rst_i,
   io_bus_arbiter_if.slave bus
);

   localparam int unsigned WAIT_INIT = (RD_LAT > 0) ? RD_LAT - 1 : 0;

   io_state_t             state;
   io_req_t   [1:0]       req_in;
   logic      [1:0]       req;
   logic                  win, win_vld;
   logic                  sel, cur_we;
   logic      [2:0]       cnt;
   logic      [1:0]       gnt, rvalid;
   logic      [1:0][DW_DEF-1:0] rdata;
   logic      [AW_DEF-1:0] io_addr;
   logic      [DW_DEF-1:0] io_wdata;
   logic                  io_we, busy;
   logic                  ptr;

   assign req       = {bus.m1_req, bus.m0_req};
   assign req_in[0] = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
   assign req_in[1] = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};

   io_arb_pick u_pick (
      .req     (req),
      .ptr     (ptr),
      .win_vld (win_vld),
      .win     (win)
   );

`ifdef IO_ARB_RR_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                          ptr <= 1'b0;
      else if (state == IDLE && win_vld)  ptr <= ~win;
   end
`else
   assign ptr = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         sel      <= 1'b0;
         cur_we   <= 1'b0;
         cnt      <= '0;
         gnt      <= '0;
         rvalid   <= '0;
         rdata    <= '0;
         io_addr  <= '0;
         io_wdata <= '0;
         io_we    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         gnt    <= '0;
         rvalid <= '0;
         io_we  <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state    <= ACCESS;
                  sel      <= win;
                  cur_we   <= req_in[win].we;
                  gnt[win] <= 1'b1;
                  io_we    <= req_in[win].we;
                  io_addr  <= req_in[win].addr;
                  io_wdata <= req_in[win].wdata;
                  busy     <= 1'b1;
               end
            end
            ACCESS: begin
               if (cur_we) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (RD_LAT == 0) begin
                  state       <= RESP;
                  rvalid[sel] <= 1'b1;
                  rdata[sel]  <= bus.io_rdata;
               end else begin
                  state <= WAIT;
                  cnt   <= 3'(WAIT_INIT);
               end
            end
            WAIT: begin
               // io_addr is untouched here so registered peripherals see a stable address
               if (cnt == '0) begin
                  state       <= RESP;
                  rvalid[sel] <= 1'b1;
                  rdata[sel]  <= bus.io_rdata;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m0_gnt    = gnt[0];
   assign bus.m1_gnt    = gnt[1];
   assign bus.m0_rvalid = rvalid[0];
   assign bus.m1_rvalid = rvalid[1];
   assign bus.m0_rdata  = rdata[0];
   assign bus.m1_rdata  = rdata[1];
   assign bus.io_addr   = io_addr;
   assign bus.io_we     = io_we;
   assign bus.io_wdata  = io_wdata;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter at RD_LAT = 1, 0 and 7 (honours IO_ARB_RR_EN).
module tb_io_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   io_bus_arbiter_if b1 ();
   io_bus_arbiter_if b0 ();
   io_bus_arbiter_if b7 ();

   io_bus_arbiter #(.RD_LAT(1)) d1 (.clk_i(clk), .rst_i(rst), .bus(b1));
   io_bus_arbiter #(.RD_LAT(0)) d0 (.clk_i(clk), .rst_i(rst), .bus(b0));
   io_bus_arbiter #(.RD_LAT(7)) d7 (.clk_i(clk), .rst_i(rst), .bus(b7));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic e1;

   initial begin
      b1.m0_req = 0; b1.m0_we = 0; b1.m0_addr = '0; b1.m0_wdata = '0;
      b1.m1_req = 0; b1.m1_we = 0; b1.m1_addr = '0; b1.m1_wdata = '0; b1.io_rdata = '0;
      b0.m0_req = 0; b0.m0_we = 0; b0.m0_addr = '0; b0.m0_wdata = '0;
      b0.m1_req = 0; b0.m1_we = 0; b0.m1_addr = '0; b0.m1_wdata = '0; b0.io_rdata = '0;
      b7.m0_req = 0; b7.m0_we = 0; b7.m0_addr = '0; b7.m0_wdata = '0;
      b7.m1_req = 0; b7.m1_we = 0; b7.m1_addr = '0; b7.m1_wdata = '0; b7.io_rdata = '0;
      #2;
      chk("rst_gnt",   {30'd0, b1.m1_gnt, b1.m0_gnt}, 32'd0);
      chk("rst_rval",  {30'd0, b1.m1_rvalid, b1.m0_rvalid}, 32'd0);
      chk("rst_addr",  32'(b1.io_addr), 32'd0);
      chk("rst_we",    32'(b1.io_we), 32'd0);
      chk("rst_busy",  32'(b1.busy), 32'd0);
      chk("rst_rdata", b1.m0_rdata | b1.m1_rdata | b1.io_wdata, 32'd0);
      tick(); rst = 0; tick();

      // reset asserted in the middle of WAIT drops the read
      b1.m0_req = 1; b1.m0_we = 0; b1.m0_addr = 12'h070;
      tick();
      chk("t1_gnt", 32'(b1.m0_gnt), 32'd1);
      b1.m0_req = 0;
      tick();
      chk("t1_wait_busy", 32'(b1.busy), 32'd1);
      rst = 1; #1;
      chk("t1_async_busy", 32'(b1.busy), 32'd0);
      chk("t1_async_addr", 32'(b1.io_addr), 32'd0);
      tick(); tick();
      chk("t1_no_rvalid", 32'(b1.m0_rvalid), 32'd0);
      rst = 0; tick();
      chk("t1_idle_rvalid", 32'(b1.m0_rvalid), 32'd0);

      // m0 read of the switch word, RD_LAT=1
      b1.m0_req = 1; b1.m0_we = 0; b1.m0_addr = 12'h070;
      tick();
      chk("t2_gnt_n1",  32'(b1.m0_gnt), 32'd1);
      chk("t2_addr_n1", 32'(b1.io_addr), 32'h070);
      chk("t2_we_n1",   32'(b1.io_we), 32'd0);
      b1.m0_req = 0;
      tick();
      b1.io_rdata = 32'hFF80_0001;
      chk("t2_gnt_n2",  32'(b1.m0_gnt), 32'd0);
      chk("t2_rval_n2", 32'(b1.m0_rvalid), 32'd0);
      chk("t2_addr_n2", 32'(b1.io_addr), 32'h070);
      tick();
      chk("t2_rval_n3",  32'(b1.m0_rvalid), 32'd1);
      chk("t2_rdata_n3", b1.m0_rdata, 32'hFF80_0001);
      b1.io_rdata = 32'hDEAD_BEEF;
      tick();
      chk("t2_rval_n4",  32'(b1.m0_rvalid), 32'd0);
      chk("t2_rdata_n4", b1.m0_rdata, 32'hFF80_0001);
      chk("t2_busy_n4",  32'(b1.busy), 32'd0);

      // m1 write: single io_we strobe, no rvalid
      b1.m1_req = 1; b1.m1_we = 1; b1.m1_addr = 12'h060; b1.m1_wdata = 32'h5A;
      tick();
      chk("t3_gnt",   {30'd0, b1.m1_gnt, b1.m0_gnt}, 32'd2);
      chk("t3_we",    32'(b1.io_we), 32'd1);
      chk("t3_addr",  32'(b1.io_addr), 32'h060);
      chk("t3_wdata", b1.io_wdata, 32'h5A);
      b1.m1_req = 0;
      tick();
      chk("t3_we_off",  32'(b1.io_we), 32'd0);
      chk("t3_rvalid",  32'(b1.m1_rvalid), 32'd0);
      chk("t3_busy",    32'(b1.busy), 32'd0);
      chk("t3_addr_hold", 32'(b1.io_addr), 32'h060);
      tick();
      chk("t3_rvalid2", 32'(b1.m1_rvalid), 32'd0);

      // both masters writing continuously
      b1.m0_req = 1; b1.m0_we = 1; b1.m0_addr = 12'h060; b1.m0_wdata = 32'hA0;
      b1.m1_req = 1; b1.m1_we = 1; b1.m1_addr = 12'h060; b1.m1_wdata = 32'hB1;
      for (int i = 0; i < 4; i++) begin
`ifdef IO_ARB_RR_EN
         e1 = (i % 2) == 1;
`else
         e1 = 1'b0;
`endif
         tick();
         chk($sformatf("t4_gnt%0d", i), {30'd0, b1.m1_gnt, b1.m0_gnt}, e1 ? 32'd2 : 32'd1);
         chk($sformatf("t4_wd%0d", i), b1.io_wdata, e1 ? 32'hB1 : 32'hA0);
         tick();
         chk($sformatf("t4_gap%0d", i), {30'd0, b1.m1_gnt, b1.m0_gnt}, 32'd0);
      end
      b1.m0_req = 0; b1.m1_req = 0;
      tick();

      // RD_LAT=0: rvalid at N+2
      b0.io_rdata = 32'h1234_5678;
      b0.m0_req = 1; b0.m0_we = 0; b0.m0_addr = 12'h070;
      tick();
      chk("t5a_gnt", 32'(b0.m0_gnt), 32'd1);
      b0.m0_req = 0;
      tick();
      chk("t5a_rval",  32'(b0.m0_rvalid), 32'd1);
      chk("t5a_rdata", b0.m0_rdata, 32'h1234_5678);

      // RD_LAT=7: address stable through all WAIT cycles, capture on the last one
      b7.m0_req = 1; b7.m0_we = 0; b7.m0_addr = 12'h074;
      tick();
      chk("t5b_gnt",  32'(b7.m0_gnt), 32'd1);
      chk("t5b_addr", 32'(b7.io_addr), 32'h074);
      b7.m0_req = 0;
      for (int k = 0; k < 7; k++) begin
         tick();
         b7.io_rdata = 32'hC000_0000 + 32'(k);
         chk($sformatf("t5b_waddr%0d", k), 32'(b7.io_addr), 32'h074);
         chk($sformatf("t5b_wrv%0d", k), {30'd0, b7.io_we, b7.m0_rvalid}, 32'd0);
      end
      tick();
      chk("t5b_rval",  32'(b7.m0_rvalid), 32'd1);
      chk("t5b_rdata", b7.m0_rdata, 32'hC000_0006);

      // rdata of the non-granted master must hold
      b1.m1_req = 1; b1.m1_we = 0; b1.m1_addr = 12'h070;
      tick();
      b1.m1_req = 0;
      b1.io_rdata = 32'h2222_2222;
      tick(); tick();
      chk("t6_m1_rval",  32'(b1.m1_rvalid), 32'd1);
      chk("t6_m0_rval",  32'(b1.m0_rvalid), 32'd0);
      chk("t6_m1_rdata", b1.m1_rdata, 32'h2222_2222);
      chk("t6_m0_hold",  b1.m0_rdata, 32'hFF80_0001);
      tick();
      b1.m0_req = 1; b1.m0_we = 0; b1.m0_addr = 12'h070;
      tick();
      b1.m0_req = 0;
      b1.io_rdata = 32'h3333_3333;
      tick(); tick();
      chk("t6b_m0_rdata", b1.m0_rdata, 32'h3333_3333);
      chk("t6b_m1_hold",  b1.m1_rdata, 32'h2222_2222);
      chk("t6b_m1_rval",  32'(b1.m1_rvalid), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
